// File: rtl/sdram_sched_pkg.sv
// Shared types and helpers for the SDRAM port scheduler and its arbiter.
package sdram_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Index width for a set of n ports (never zero).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of port's field inside a packed per-port address bus.
    function automatic int addr_lo(input int port, input int addr_w);
        return port * addr_w;
    endfunction

    // Low bit of port's field inside a packed per-port data bus.
    function automatic int data_lo(input int port, input int data_w);
        return port * data_w;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Round-robin picker: first eligible request at or above ptr_i, with wrap.
module sdram_rr_pick
    import sdram_sched_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  exclude_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    // Scan from the farthest candidate down so the nearest one to ptr_i wins.
    always_comb begin
        logic [N-1:0]  eligible;
        logic [IW-1:0] idx;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        winner_o = '0;
        valid_o  = 1'b0;
        eligible = pending_i & ~exclude_i;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (eligible[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares one SDRAM channel between NUM_PORTS toggle-handshake host ports.
// Round-robin arbitration, optional priority for port 0 bounded by a streak limit.
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int PRIO0      = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            host_req,
    input  logic [NUM_PORTS-1:0]            host_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]     host_address,
    input  logic [NUM_PORTS*DATA_W-1:0]     host_data_write,
    output logic [NUM_PORTS-1:0]            host_ack,
    output logic [NUM_PORTS*DATA_W-1:0]     host_data_read,
    output logic                            dev_req,
    output logic                            dev_we,
    output logic [ADDR_W-1:0]               dev_address,
    output logic [DATA_W-1:0]               dev_data_write,
    input  logic                            dev_ack,
    input  logic [DATA_W-1:0]               dev_data_read,
    output logic                            busy,
    output logic [$clog2(NUM_PORTS)-1:0]    grant
);

    localparam int IDX_W  = idx_w(NUM_PORTS);
    localparam int STRK_W = $clog2(MAX_STREAK + 1);

    state_e                        state_q, state_d;
    logic [NUM_PORTS-1:0]          ack_q, ack_d;
    logic [NUM_PORTS*DATA_W-1:0]   rdata_q, rdata_d;
    logic                          dev_req_q, dev_req_d;
    logic                          dev_we_q, dev_we_d;
    logic [ADDR_W-1:0]             dev_addr_q, dev_addr_d;
    logic [DATA_W-1:0]             dev_wdata_q, dev_wdata_d;
    logic [IDX_W-1:0]              grant_q, grant_d;
    logic [IDX_W-1:0]              rr_q, rr_d;
    logic [STRK_W-1:0]             streak_q, streak_d;
    logic                          contended_q, contended_d;

    logic [NUM_PORTS-1:0]          pending;
    logic                          others_pending;
    logic                          prio0_win;
    logic                          limiter_forced;
    logic [IDX_W-1:0]              pick_idx;
    logic                          pick_valid;
    logic [IDX_W-1:0]              winner;
    logic                          done;

    assign pending        = host_req ^ ack_q;
    assign others_pending = |pending[NUM_PORTS-1:1];
    assign prio0_win      = (PRIO0 != 0) && pending[0] &&
                            ((streak_q < STRK_W'(MAX_STREAK)) || !others_pending);
    assign limiter_forced = (PRIO0 != 0) && pending[0] && !prio0_win;
    assign winner         = prio0_win ? '0 : pick_idx;
    assign done           = (state_q == BUSY) && (dev_ack == dev_req_q);

    sdram_rr_pick #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_pick (
        .pending_i (pending),
        .ptr_i     (rr_q),
        .exclude_i ({{(NUM_PORTS-1){1'b0}}, limiter_forced}),
        .winner_o  (pick_idx),
        .valid_o   (pick_valid)
    );

    // Next-state: grant and latch a request in IDLE, retire it in BUSY on matching ack.
    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        streak_d    = streak_q;
        contended_d = contended_q;
        case (state_q)
            IDLE: begin
                if (prio0_win || pick_valid) begin
                    dev_we_d    = host_we[winner];
                    dev_addr_d  = host_address[addr_lo(int'(winner), ADDR_W) +: ADDR_W];
                    dev_wdata_d = host_data_write[data_lo(int'(winner), DATA_W) +: DATA_W];
                    dev_req_d   = ~dev_req_q;
                    grant_d     = winner;
                    contended_d = others_pending;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    rdata_d[data_lo(int'(grant_q), DATA_W) +: DATA_W] = dev_data_read;
                    ack_d[grant_q] = ~ack_q[grant_q];
                    rr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
                    if (grant_q != '0) begin
                        streak_d = '0;
                    end else if (contended_q && (streak_q < STRK_W'(MAX_STREAK))) begin
                        streak_d = streak_q + STRK_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            // NOTE: the per-port read-data registers are reset too; hosts may see them before any read.
            rdata_q     <= '0;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            grant_q     <= '0;
            rr_q        <= '0;
            streak_q    <= '0;
            contended_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            streak_q    <= streak_d;
            contended_q <= contended_d;
        end
    end

    assign host_ack       = ack_q;
    assign host_data_read = rdata_q;
    assign dev_req        = dev_req_q;
    assign dev_we         = dev_we_q;
    assign dev_address    = dev_addr_q;
    assign dev_data_write = dev_wdata_q;
    assign busy           = (state_q == BUSY);
    assign grant          = grant_q;

    // The device must not answer while nothing is outstanding.
    a_no_idle_ack : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> (dev_ack == dev_req_q));

    // A host must not re-toggle its request until its ack has come back.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req_chk
        a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
            $past(pending[i] && !(done && (grant_q == IDX_W'(i)))) |->
            (host_req[i] == $past(host_req[i])));
    end

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Scoreboard bench for sdram_port_scheduler with a fixed-latency SDRAM channel model.
module tb_sdram_port_scheduler;

    localparam int NP  = 3;
    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int LAT = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     host_req;
    logic [NP-1:0]     host_we;
    logic [NP*AW-1:0]  host_address;
    logic [NP*DW-1:0]  host_data_write;
    logic [NP-1:0]     host_ack;
    logic [NP*DW-1:0]  host_data_read;
    logic              dev_req;
    logic              dev_we;
    logic [AW-1:0]     dev_address;
    logic [DW-1:0]     dev_data_write;
    logic              dev_ack;
    logic [DW-1:0]     dev_data_read;
    logic              busy;
    logic [1:0]        grant;

    sdram_port_scheduler #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO0(1), .MAX_STREAK(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we),
        .host_address(host_address), .host_data_write(host_data_write),
        .host_ack(host_ack), .host_data_read(host_data_read),
        .dev_req(dev_req), .dev_we(dev_we), .dev_address(dev_address),
        .dev_data_write(dev_data_write), .dev_ack(dev_ack),
        .dev_data_read(dev_data_read), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SDRAM channel model ----------------
    logic [DW-1:0] mem [int];
    logic          dv_seen;
    int            dv_cnt;
    logic          dv_we;
    logic [AW-1:0] dv_addr;
    logic [DW-1:0] dv_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_ack       <= 1'b0;
            dev_data_read <= '0;
            dv_seen       <= 1'b0;
            dv_cnt        <= 0;
        end else if (dv_cnt != 0) begin
            if (dv_cnt == 1) begin
                dev_ack <= ~dev_ack;
                if (dv_we) begin
                    mem[int'(dv_addr)] = dv_wdata;
                    dev_data_read <= dv_wdata;
                end else begin
                    dev_data_read <= mem.exists(int'(dv_addr)) ? mem[int'(dv_addr)] : 16'hDEAD;
                end
            end
            dv_cnt <= dv_cnt - 1;
        end else if (dev_req != dv_seen) begin
            dv_seen  <= dev_req;
            dv_cnt   <= LAT - 1;
            dv_we    <= dev_we;
            dv_addr  <= dev_address;
            dv_wdata <= dev_data_write;
        end
    end

    // ---------------- Scoreboard ----------------
    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t exp_grant[$];
    txn_t exp_ack[$];

    task automatic expect_txn(input int port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_grant.push_back(t);
        exp_ack.push_back(t);
    endtask

    logic          prev_dev_req;
    logic [NP-1:0] prev_ack;
    logic [NP*DW-1:0] prev_rdata;

    // Monitor: checks each grant and each ack against the expected queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dev_req = dev_req;
            prev_ack     = host_ack;
            prev_rdata   = host_data_read;
        end else begin
            if (dev_req !== prev_dev_req) begin
                check("grant_expected", 64'(exp_grant.size() != 0), 64'd1);
                if (exp_grant.size() != 0) begin
                    txn_t t;
                    t = exp_grant.pop_front();
                    check("grant_port", 64'(grant), 64'(t.port));
                    check("grant_busy", 64'(busy), 64'd1);
                    check("dev_we", 64'(dev_we), 64'(t.we));
                    check("dev_address", 64'(dev_address), 64'(t.addr));
                    if (t.we) check("dev_data_write", 64'(dev_data_write), 64'(t.wdata));
                end
            end
            if (host_ack !== prev_ack) begin
                logic [NP-1:0] changed;
                changed = host_ack ^ prev_ack;
                check("ack_expected", 64'(exp_ack.size() != 0), 64'd1);
                if (exp_ack.size() != 0) begin
                    txn_t t;
                    t = exp_ack.pop_front();
                    check("ack_port_onehot", 64'(changed), 64'(3'b001 << t.port));
                    check("host_data_read", 64'(host_data_read[t.port*DW +: DW]), 64'(t.rdata));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (host_ack[p] === prev_ack[p])
                    check("data_hold", 64'(host_data_read[p*DW +: DW]), 64'(prev_rdata[p*DW +: DW]));
            end
            prev_dev_req = dev_req;
            prev_ack     = host_ack;
            prev_rdata   = host_data_read;
        end
    end

    // ---------------- Host driver ----------------
    // Issues n back-to-back requests on one port, re-toggling as soon as each ack is seen.
    task automatic do_req(input int port, input int n, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat);
        int t0;
        int waited;
        lat = 0;
        for (int k = 0; k < n; k++) begin
            host_we[port] = we;
            host_address[port*AW +: AW] = addr;
            host_data_write[port*DW +: DW] = wdata;
            host_req[port] = ~host_req[port];
            t0 = cyc;
            waited = 0;
            while (host_ack[port] !== host_req[port] && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check("ack_arrived", 64'(host_ack[port]), 64'(host_req[port]));
            lat = cyc - t0;
        end
    endtask

    task automatic wait_busy();
        int w = 0;
        while (!busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("busy_seen", 64'(busy), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_host_ack", 64'(host_ack), 64'd0);
        check("rst_dev_req", 64'(dev_req), 64'd0);
        check("rst_dev_we", 64'(dev_we), 64'd0);
        check("rst_dev_address", 64'(dev_address), 64'd0);
        check("rst_dev_data_write", 64'(dev_data_write), 64'd0);
        check("rst_host_data_read", 64'(host_data_read), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        host_req = '0;
        exp_grant.delete();
        exp_ack.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat0, lat1, lat2;
        rst_n = 1'b0;
        host_req = '0;
        host_we = '0;
        host_address = '0;
        host_data_write = '0;
        mem[32'h00123] = 16'hBEEF;
        mem[32'h00200] = 16'h1111;
        mem[32'h00300] = 16'h2222;
        mem[32'h00010] = 16'h0A0A;
        mem[32'h00020] = 16'h2020;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read on port 1: 2 cycles plus 5 device cycles to ack.
        expect_txn(1, 1'b0, 22'h00123, 16'h0000, 16'hBEEF);
        do_req(1, 1, 1'b0, 22'h00123, 16'h0000, lat1);
        check("read_latency", 64'(lat1), 64'd7);
        @(negedge clk);

        // Simultaneous ports 1 and 2 from pointer 0: served 1 then 2.
        apply_reset();
        expect_txn(1, 1'b0, 22'h00200, 16'h0000, 16'h1111);
        expect_txn(2, 1'b0, 22'h00300, 16'h0000, 16'h2222);
        fork
            do_req(1, 1, 1'b0, 22'h00200, 16'h0000, lat1);
            do_req(2, 1, 1'b0, 22'h00300, 16'h0000, lat2);
        join
        @(negedge clk);

        // Write on port 0; latched fields must not follow later host changes.
        expect_txn(0, 1'b1, 22'h3FFFFF, 16'h5A5A, 16'h5A5A);
        host_we[0] = 1'b1;
        host_address[0 +: AW] = 22'h3FFFFF;
        host_data_write[0 +: DW] = 16'h5A5A;
        host_req[0] = ~host_req[0];
        wait_busy();
        host_we[0] = 1'b0;
        host_address[0 +: AW] = 22'h000111;
        host_data_write[0 +: DW] = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            check("hold_dev_we", 64'(dev_we), 64'd1);
            check("hold_dev_address", 64'(dev_address), 64'h3FFFFF);
            check("hold_dev_data_write", 64'(dev_data_write), 64'h5A5A);
        end
        begin
            int w = 0;
            while (host_ack[0] !== host_req[0] && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("write_ack", 64'(host_ack[0]), 64'(host_req[0]));
        end
        @(negedge clk);

        // Ports 0,1,2 pending with pointer at 1: port 0 first by priority, then 1, 2.
        expect_txn(0, 1'b0, 22'h00010, 16'h0000, 16'h0A0A);
        expect_txn(1, 1'b0, 22'h00200, 16'h0000, 16'h1111);
        expect_txn(2, 1'b0, 22'h00300, 16'h0000, 16'h2222);
        fork
            do_req(0, 1, 1'b0, 22'h00010, 16'h0000, lat0);
            do_req(1, 1, 1'b0, 22'h00200, 16'h0000, lat1);
            do_req(2, 1, 1'b0, 22'h00300, 16'h0000, lat2);
        join
        @(negedge clk);

        // Streak limiter: port 0 hammers, port 2 waits; expect 0,0,0,0,2 twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) expect_txn(0, 1'b0, 22'h00010, 16'h0000, 16'h0A0A);
            expect_txn(2, 1'b0, 22'h00020, 16'h0000, 16'h2020);
        end
        fork
            do_req(0, 8, 1'b0, 22'h00010, 16'h0000, lat0);
            do_req(2, 2, 1'b0, 22'h00020, 16'h0000, lat2);
        join
        @(negedge clk);

        // Reset two cycles into a transaction aborts it immediately.
        begin
            txn_t t;
            t.port = 1; t.we = 1'b0; t.addr = 22'h00200; t.wdata = '0; t.rdata = '0;
            exp_grant.push_back(t);
        end
        host_address[1*AW +: AW] = 22'h00200;
        host_we[1] = 1'b0;
        host_req[1] = ~host_req[1];
        wait_busy();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        host_req = '0;
        #1;
        check_reset_outputs();
        exp_grant.delete();
        exp_ack.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_txn(2, 1'b0, 22'h00300, 16'h0000, 16'h2222);
        do_req(2, 1, 1'b0, 22'h00300, 16'h0000, lat2);
        check("post_reset_latency", 64'(lat2), 64'd7);
        repeat (3) @(negedge clk);

        check("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
        check("ack_queue_drained", 64'(exp_ack.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_scheduler.md
Name: sdram_port_scheduler

Overview:
Shares one SDRAM controller channel between NUM_PORTS host ports that use the toggle req/ack handshake. Scheduling is round-robin, with optional fixed priority for port 0, the cartridge-bus port with real-time deadlines. A streak limiter stops port 0 from starving the other ports. The block sits between the host-side ports (API, loader, FC bus) and one SDRAM controller channel, in place of static muxing.

Parameters:
NUM_PORTS, 3, number of host ports (2..8).
ADDR_W, 22, word address width.
DATA_W, 16, data width.
PRIO0, 1, 1 = port 0 wins over any other pending port; 0 = pure round-robin.
MAX_STREAK, 4, maximum consecutive port-0 grants while another port is pending (PRIO0=1 only; >=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_req  in  NUM_PORTS  per-port request toggle
host_we  in  NUM_PORTS  per-port write enable
host_address  in  NUM_PORTS*ADDR_W  packed per-port address
host_data_write  in  NUM_PORTS*DATA_W  packed per-port write data
host_ack  out  NUM_PORTS  per-port acknowledge toggle
host_data_read  out  NUM_PORTS*DATA_W  packed per-port read data, registered
dev_req  out  1  request toggle to SDRAM channel
dev_we  out  1  latched write enable
dev_address  out  ADDR_W  latched address
dev_data_write  out  DATA_W  latched write data
dev_ack  in  1  acknowledge toggle from SDRAM channel
dev_data_read  in  DATA_W  read data, valid when dev_ack equals dev_req
busy  out  1  high in state BUSY
grant  out  $clog2(NUM_PORTS)  index of the port being served; valid while busy

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - host_ack=0, dev_req=0, dev_we=0, dev_address=0, dev_data_write=0.
  - All host_data_read=0, grant=0, rr pointer=0, streak=0, busy=0.
- Pending definition: port i is pending when host_req[i] != host_ack[i].
- Host contract: a host holds we/address/data_write stable while its request is pending. The block still latches these fields at grant.
- IDLE, with at least one port pending:
  - Select a winner by the rules below and latch its we/address/data into the dev_* registers.
  - Toggle dev_req, set grant, go to BUSY. All of this happens in the same clock edge.
  - dev_req toggles one cycle after host_req toggles.
- Selection rules:
  - PRIO0=1, port 0 pending, and (streak < MAX_STREAK or no other port pending): port 0 wins.
  - Otherwise: the first pending port at or after the rr pointer wins, searching upward with wrap, excluding port 0 when the limiter forced the choice.
  - PRIO0=0: pure round-robin from the rr pointer.
- BUSY, on the edge where dev_ack == dev_req:
  - host_data_read[grant] <= dev_data_read (captured on reads and writes).
  - host_ack[grant] toggles.
  - rr pointer <= grant+1, mod NUM_PORTS.
  - streak: +1 if grant==0 and another port was pending at selection; 0 if grant!=0; saturates at MAX_STREAK.
  - Return to IDLE.
- Latency: host_ack toggles one cycle after dev_ack matches. Minimum turnaround from host_req toggle to host_ack toggle is 2 cycles plus device latency. The next grant comes no earlier than the cycle after ack (one idle cycle between transactions).
- Other ports' acks and data never change while not granted.
- A host toggling req again before its ack is a contract violation; behaviour is undefined, and a simulation assertion flags it.
- dev_ack toggling while in IDLE is ignored; a simulation assertion flags it.
- Reset mid-BUSY aborts the transaction. The SDRAM channel shares rst_n and is reset at the same time.

Decomposition:
- Package sdram_sched_pkg holds:
  - the state enum (IDLE, BUSY);
  - the index-width function;
  - the packed-slice helpers for address and data.
- Sub-module sdram_rr_pick: combinational. Inputs pending mask, pointer and exclude mask; outputs winner index and a valid flag. Reused by other arbiters in the design.

Test Plan:
- Single read: port 1 toggles req, address=0x00123; device returns 0xBEEF after 5 cycles -> dev_address=0x00123 and dev_we=0; host_ack[1] toggles at cycle 7; host_data_read[1]=0xBEEF.
- Simultaneous requests on ports 1 and 2 (PRIO0=0, ptr=0) -> grant order 1, then 2; each host_ack toggles exactly once; port 2 data is unaffected during port 1's transaction.
- PRIO0=1: ports 0, 1 and 2 are pending at once -> port 0 is served first.
- Starvation limit: PRIO0=1, MAX_STREAK=4, port 0 re-requests immediately after every ack while port 2 is continuously pending -> port 0 is granted 4 times, port 2 is granted 5th, and the streak resets.
- Write: port 0, we=1, address=0x3FFFFF, data=0x5A5A -> dev fields match the latched values, and they stay stable when host inputs change after the grant.
- Reset mid-BUSY: assert rst_n=0 two cycles after grant -> all outputs return to their reset values immediately; after release, a new request completes normally.
